// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   tx_state_e : transmitter frame states (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN / PAR_ODD : values accepted by the PARITY_ODD parameter
//   BIT_CNT_W  : width of the per-frame bit counter (covers up to 9 data bits)
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered occupancy count. The head word is
// presented combinationally on o_data so a pop and its data use the same edge.
// Ports:
//   i_clk, i_rst : clock and synchronous active-high reset
//   i_push       : write i_data (ignored while full)
//   i_pop        : drop the head word (ignored while empty)
//   i_data       : word to write
//   o_data       : current head word
//   o_count      : words held, 0..DEPTH
//   o_full       : o_count == DEPTH
//   o_empty      : o_count == 0
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rdPtr_q];

  assign doPush = i_push && !o_full;
  assign doPop  = i_pop && !o_empty;

  // Pointer and count update. DEPTH is a power of two, so the pointers wrap
  // naturally by overflowing their width. A push and pop on the same edge
  // both happen and leave the count where it was.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array. It is not cleared on reset; the count decides what is valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst && doPush) begin
      mem_q[wrPtr_q] <= i_data;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter: words written on i_data/i_valid queue in a
// sync_fifo and are sent as start bit, DATA_W data bits LSB first, optional
// parity bit and STOP_BITS stop bits, each bit lasting CLKS_PER_BIT cycles.
// Ports:
//   i_clk, i_rst : clock and synchronous active-high reset
//   i_data       : word to transmit
//   i_valid      : write request, accepted when o_ready is high
//   o_ready      : FIFO not full
//   o_tx         : registered serial output, idle high
//   o_busy       : frame in progress
//   o_count      : words waiting in the FIFO
//   o_overflow   : sticky flag, set by a write attempted while full
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [DATA_W-1:0]           i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                        o_overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cycleCnt_q, cycleCnt_d;
  logic [BIT_CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  overflow_q, overflow_d;

  logic                  fifoPush;
  logic                  popReq;
  logic [DATA_W-1:0]     fifoData;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  lastCycle;

  assign o_ready    = !fifoFull;
  assign fifoPush   = i_valid && o_ready;
  assign o_tx       = tx_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_overflow = overflow_q;
  assign lastCycle  = (cycleCnt_q == CNT_W'(CLKS_PER_BIT - 1));

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifoPush),
    .i_pop   (popReq),
    .i_data  (i_data),
    .o_data  (fifoData),
    .o_count (o_count),
    .o_full  (fifoFull),
    .o_empty (fifoEmpty)
  );

  // Frame sequencing. The cycle counter paces every bit; the bit counter
  // tracks data bits in DATA and stop bits in STOP. A new frame starts either
  // from IDLE or straight out of the last stop cycle, so queued words go out
  // with no idle gap. Starting a frame pops the head word into the shifter,
  // captures its parity and drives the start bit on the same edge.
  always_comb begin
    state_d    = state_q;
    cycleCnt_d = cycleCnt_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    popReq     = 1'b0;
    overflow_d = overflow_q | (i_valid & fifoFull);

    if (state_q != ST_IDLE) begin
      cycleCnt_d = lastCycle ? '0 : cycleCnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        popReq = !fifoEmpty;
      end
      ST_START: begin
        if (lastCycle) begin
          state_d  = ST_DATA;
          bitCnt_d = '0;
          tx_d     = shift_q[0];
          shift_d  = shift_q >> 1;
        end
      end
      ST_DATA: begin
        if (lastCycle) begin
          if (bitCnt_q == BIT_CNT_W'(DATA_W - 1)) begin
            bitCnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
            tx_d     = shift_q[0];
            shift_d  = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (lastCycle) begin
          state_d  = ST_STOP;
          bitCnt_d = '0;
          tx_d     = 1'b1;
        end
      end
      ST_STOP: begin
        if (lastCycle) begin
          if (bitCnt_q == BIT_CNT_W'(STOP_BITS - 1)) begin
            state_d  = ST_IDLE;
            bitCnt_d = '0;
            tx_d     = 1'b1;
            popReq   = !fifoEmpty;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (popReq) begin
      state_d    = ST_START;
      cycleCnt_d = '0;
      bitCnt_d   = '0;
      shift_d    = fifoData;
      parity_d   = (^fifoData) ^ (PARITY_ODD != PAR_EVEN);
      tx_d       = 1'b0;
    end
  end

  // Transmitter state register. Reset aborts any frame and returns the line
  // to idle-high on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cycleCnt_q <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycleCnt_q <= cycleCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Two transmitters share one clock and reset: instance 0 uses the default
// parameters, instance 1 adds even parity, two stop bits and a 4-word FIFO.
// A queue-and-timeline model predicts every output every cycle: a frame is a
// list of bits indexed by elapsed cycles / CLKS_PER_BIT, and the buffer is a
// plain circular array of accepted words.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid0, valid1;
  logic [7:0] data0, data1;
  logic       tx0, busy0, ready0, ovf0;
  logic       tx1, busy1, ready1, ovf1;
  logic [3:0] count0;
  logic [2:0] count1;

  int checks   = 0;
  int failures = 0;

  int cfgCpb   [2] = '{16, 16};
  int cfgPar   [2] = '{0, 1};
  int cfgOdd   [2] = '{0, 0};
  int cfgStop  [2] = '{1, 2};
  int cfgDepth [2] = '{8, 4};
  int flen     [2];

  int mem     [2][16];
  int head    [2];
  int size    [2];
  int elapsed [2];
  int cur     [2];
  bit active  [2];
  bit ovfM    [2];

  int pat0 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int pat1 [12] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_W(8), .CLKS_PER_BIT(16), .FIFO_DEPTH(8),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .i_data(data0), .i_valid(valid0),
    .o_ready(ready0), .o_tx(tx0), .o_busy(busy0), .o_count(count0),
    .o_overflow(ovf0)
  );

  uart_tx_fifo #(
    .DATA_W(8), .CLKS_PER_BIT(16), .FIFO_DEPTH(4),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
  ) dut1 (
    .i_clk(clk), .i_rst(rst), .i_data(data1), .i_valid(valid1),
    .o_ready(ready1), .o_tx(tx1), .o_busy(busy1), .o_count(count1),
    .o_overflow(ovf1)
  );

  // Bit idx of a frame carrying word: start, 8 data bits, parity, stops.
  function automatic int frameBit(int k, int word, int idx);
    if (idx == 0) return 0;
    if (idx <= 8) return (word >> (idx - 1)) & 1;
    if (cfgPar[k] != 0 && idx == 9) return ($countones(word & 'hFF) % 2) ^ cfgOdd[k];
    return 1;
  endfunction

  function automatic int expTx(int k);
    if (!active[k]) return 1;
    return frameBit(k, cur[k], elapsed[k] / cfgCpb[k]);
  endfunction

  // One rising edge of the reference: a frame is started whenever the line
  // is free (or finishing its last cycle) and a word is waiting; writes are
  // accepted only if the buffer was not full before the edge.
  task automatic modelEdge(int k, bit r, bit v, int d);
    bit popNow;
    bit pushNow;
    if (r) begin
      head[k] = 0; size[k] = 0; active[k] = 0; elapsed[k] = 0; ovfM[k] = 0;
      return;
    end
    popNow  = (!active[k] || elapsed[k] == flen[k] - 1) && size[k] != 0;
    pushNow = v && size[k] < cfgDepth[k];
    if (v && size[k] == cfgDepth[k]) ovfM[k] = 1;
    if (active[k]) begin
      elapsed[k]++;
      if (elapsed[k] == flen[k]) active[k] = 0;
    end
    if (popNow) begin
      cur[k]     = mem[k][head[k]];
      head[k]    = (head[k] + 1) % cfgDepth[k];
      size[k]    = size[k] - 1;
      active[k]  = 1;
      elapsed[k] = 0;
    end
    if (pushNow) begin
      mem[k][(head[k] + size[k]) % cfgDepth[k]] = d & 'hFF;
      size[k] = size[k] + 1;
    end
  endtask

  task automatic checkOutput(string tag, int actual, int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkInst(int k);
    if (k == 0) begin
      checkOutput("tx0",    int'(tx0),    expTx(0));
      checkOutput("busy0",  int'(busy0),  int'(active[0]));
      checkOutput("count0", int'(count0), size[0]);
      checkOutput("ready0", int'(ready0), (size[0] < cfgDepth[0]) ? 1 : 0);
      checkOutput("ovf0",   int'(ovf0),   int'(ovfM[0]));
    end else begin
      checkOutput("tx1",    int'(tx1),    expTx(1));
      checkOutput("busy1",  int'(busy1),  int'(active[1]));
      checkOutput("count1", int'(count1), size[1]);
      checkOutput("ready1", int'(ready1), (size[1] < cfgDepth[1]) ? 1 : 0);
      checkOutput("ovf1",   int'(ovf1),   int'(ovfM[1]));
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge(0, rst, valid0, int'(data0));
    modelEdge(1, rst, valid1, int'(data1));
    @(negedge clk);
    checkInst(0);
    checkInst(1);
  endtask

  task automatic applyStimulus(bit r, bit v0, int d0, bit v1, int d1);
    rst    = r;
    valid0 = v0;
    data0  = d0[7:0];
    valid1 = v1;
    data1  = d1[7:0];
    stepCycle();
  endtask

  task automatic waitIdle(int bound);
    for (int i = 0; i < bound && (busy0 || busy1 || count0 != 0 || count1 != 0); i++) begin
      applyStimulus(0, 0, 0, 0, 0);
    end
    checkOutput("idleBusy", int'(busy0) * 2 + int'(busy1), 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      flen[k] = (1 + 8 + cfgPar[k] + cfgStop[k]) * cfgCpb[k];
      head[k] = 0; size[k] = 0; elapsed[k] = 0; cur[k] = 0;
      active[k] = 0; ovfM[k] = 0;
    end
    rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;
    @(negedge clk);

    // Reset with writes requested: they must be ignored.
    applyStimulus(1, 1, 'h5A, 1, 'h5A);
    applyStimulus(1, 1, 'h5A, 1, 'h5A);
    checkOutput("rstTx",    int'(tx0),    1);
    checkOutput("rstBusy",  int'(busy0),  0);
    checkOutput("rstCount", int'(count0), 0);
    checkOutput("rstReady", int'(ready0), 1);
    checkOutput("rstOvf",   int'(ovf0),   0);
    applyStimulus(0, 0, 0, 0, 0);

    // Single frames: 0xA5 on the plain port, 0x07 on the parity/2-stop port.
    applyStimulus(0, 1, 'hA5, 1, 'h07);
    checkOutput("latCount", int'(count0), 1);
    checkOutput("latTxIdle", int'(tx0), 1);
    applyStimulus(0, 0, 0, 0, 0);
    for (int t = 0; t <= 192; t++) begin
      if (t == 0) checkOutput("latStart", int'(tx0), 0);
      if (t < 160 && t % 16 == 8) checkOutput("pat0", int'(tx0), pat0[t / 16]);
      if (t < 192 && t % 16 == 8) checkOutput("pat1", int'(tx1), pat1[t / 16]);
      if (t == 159) checkOutput("busyEnd0", int'(busy0), 1);
      if (t == 160) checkOutput("busyOff0", int'(busy0), 0);
      if (t == 191) checkOutput("busyEnd1", int'(busy1), 1);
      if (t == 192) checkOutput("busyOff1", int'(busy1), 0);
      if (t < 192) applyStimulus(0, 0, 0, 0, 0);
    end

    // Three words back to back; the first is popped as the second arrives.
    applyStimulus(0, 1, 'h11, 0, 0);
    applyStimulus(0, 1, 'h22, 0, 0);
    applyStimulus(0, 1, 'h33, 0, 0);
    checkOutput("b2bCount", int'(count0), 2);
    waitIdle(700);

    // Fill while transmitting, then keep pushing across a pop edge.
    applyStimulus(0, 1, $urandom, 1, $urandom);
    repeat (20) applyStimulus(0, 0, 0, 0, 0);
    repeat (10) applyStimulus(0, 1, $urandom, 1, $urandom);
    checkOutput("fullCount", int'(count0), 8);
    checkOutput("fullReady", int'(ready0), 0);
    checkOutput("fullOvf0",  int'(ovf0),   1);
    checkOutput("fullOvf1",  int'(ovf1),   1);
    repeat (160) applyStimulus(0, 1, $urandom, 1, $urandom);
    checkOutput("refillCount", int'(count0), 8);
    waitIdle(2200);

    // Reset in the middle of the data bits with words still queued.
    applyStimulus(0, 1, 'h3C, 1, 'hC3);
    applyStimulus(0, 1, 'h81, 1, 'h18);
    applyStimulus(0, 1, 'h42, 0, 0);
    repeat (70) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("midRstTx",    int'(tx0),    1);
    checkOutput("midRstBusy",  int'(busy0),  0);
    checkOutput("midRstCount", int'(count0), 0);
    checkOutput("midRstOvf",   int'(ovf0),   0);
    repeat (200) applyStimulus(0, 0, 0, 0, 0);

    // Random traffic with varying write density and rare resets.
    for (int seg = 0; seg < 10; seg++) begin
      int p;
      p = (seg % 5 == 0) ? 0 : (seg % 5 == 1) ? 2 : (seg % 5 == 2) ? 10 :
          (seg % 5 == 3) ? 60 : 100;
      for (int c = 0; c < 250; c++) begin
        applyStimulus($urandom_range(0, 1999) == 0,
                      $urandom_range(0, 99) < p, $urandom,
                      $urandom_range(0, 99) < p, $urandom);
      end
    end
    waitIdle(2500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
